// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD engine: state encoding and operand width helper.
package gcd_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = IDLE,
        S_CALC = CALC,
        S_DONE = DONE
    } gcd_state_e;

    // Operand width for an N-digit comparator (two bits per digit).
    function automatic int unsigned gcd_width(input int unsigned n);
        return 2 * n;
    endfunction

endpackage

// File: rtl/twoN_bitcomparator.sv
// Cascadable 2N-bit magnitude comparator built from N two-bit digits, MSB digit first.
// xgtyin/xltyin carry a decision from a more significant stage; tie both low for a standalone unit.
module twoN_bitcomparator #(
    parameter int unsigned N = 4
) (
    input  logic [2*N-1:0] x,
    input  logic [2*N-1:0] y,
    input  logic           xgtyin,
    input  logic           xltyin,
    output logic           xgty,
    output logic           xlty,
    output logic           xety
);

    logic gt;
    logic lt;

    // Walk digits from most significant down; the first differing digit decides.
    always_comb begin
        gt = xgtyin;
        lt = xltyin;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (!gt && !lt) begin
                if (x[2*i +: 2] > y[2*i +: 2]) begin
                    gt = 1'b1;
                end else if (x[2*i +: 2] < y[2*i +: 2]) begin
                    lt = 1'b1;
                end
            end
        end
        xgty = gt;
        xlty = lt;
        xety = !gt && !lt;
    end

endmodule

// File: rtl/gcd_engine.sv
// Iterative subtract-and-compare GCD unit with valid/ready handshakes on both sides.
// Optional feature: define GCD_ITER_COUNT_EN to add the iter_cnt port and its counter.
module gcd_engine
    import gcd_pkg::*;
#(
    parameter  int unsigned N = 4,
    localparam int unsigned W = gcd_width(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_gcd,
    output logic         busy
`ifdef GCD_ITER_COUNT_EN
    ,
    output logic [W-1:0] iter_cnt
`endif
);

    gcd_state_e   state;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         x_zero;
    logic         y_zero;
    logic         xgty;
    logic         xlty;
    logic         xety;

    twoN_bitcomparator #(.N(N)) u_cmp (
        .x      (x),
        .y      (y),
        .xgtyin (1'b0),
        .xltyin (1'b0),
        .xgty   (xgty),
        .xlty   (xlty),
        .xety   (xety)
    );

    assign x_zero = (x == '0);
    assign y_zero = (y == '0);

    // Control FSM, operand registers and registered handshake flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            x         <= '0;
            y         <= '0;
            out_gcd   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        x        <= in_a;
                        y        <= in_b;
                        state    <= S_CALC;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                S_CALC: begin
                    if (x_zero) begin
                        out_gcd   <= y;
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                    end else if (y_zero || xety) begin
                        out_gcd   <= x;
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                    end else if (xgty) begin
                        x <= x - y;
                    end else if (xlty) begin
                        y <= y - x;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

`ifdef GCD_ITER_COUNT_EN
    // CALC cycle counter: cleared on accept, counts every CALC cycle, held through DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            iter_cnt <= '0;
        end else if (state == S_IDLE && in_valid) begin
            iter_cnt <= '0;
        end else if (state == S_CALC) begin
            iter_cnt <= iter_cnt + W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_gcd_engine.sv
// Directed self-checking bench for gcd_engine (N=4, 8-bit operands).
module tb_gcd_engine;

    localparam int unsigned N = 4;
    localparam int unsigned W = 2 * N;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_gcd;
    logic         busy;
`ifdef GCD_ITER_COUNT_EN
    logic [W-1:0] iter_cnt;
`endif

    int checks = 0;
    int errors = 0;

    gcd_engine #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_gcd   (out_gcd),
        .busy      (busy)
`ifdef GCD_ITER_COUNT_EN
        ,
        .iter_cnt  (iter_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int ref_gcd(input int a, input int b);
        int p = a;
        int q = b;
        while (q != 0) begin
            int t = p % q;
            p = q;
            q = t;
        end
        return p;
    endfunction

    // Present a pair, wait for acceptance, then count CALC edges until out_valid.
    task automatic start_and_wait(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output int cycles);
        int guard = 0;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        while (!in_ready && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = ~a;
        in_b     = ~b;
        cycles   = 0;
        while (!out_valid && cycles < 2000) begin
            @(negedge clk);
            cycles++;
        end
        if (!out_valid) check_eq("timeout_out_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_pair(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input int exp_gcd, input int exp_cycles);
        int cyc;
        start_and_wait(a, b, cyc);
        check_eq({tag, "_gcd"}, 32'(out_gcd), 32'(exp_gcd));
        check_eq({tag, "_cycles"}, 32'(cyc), 32'(exp_cycles));
`ifdef GCD_ITER_COUNT_EN
        check_eq({tag, "_iter_cnt"}, 32'(iter_cnt), 32'(exp_cycles));
`endif
        release_result();
    endtask

    logic [W-1:0] pa [20];
    logic [W-1:0] pb [20];

    initial begin
        int cyc;
        logic [W-1:0] held;
        int idx;
        int ridx;
        int budget;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_out_gcd", 32'(out_gcd), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Normal, zero-operand, equal and worst-case pairs.
        run_pair("p12_18", 8'd12, 8'd18, 6, 3);
        run_pair("p0_45", 8'd0, 8'd45, 45, 1);
        run_pair("p45_0", 8'd45, 8'd0, 45, 1);
        run_pair("p0_0", 8'd0, 8'd0, 0, 1);
        run_pair("p7_7", 8'd7, 8'd7, 7, 1);
        run_pair("p255_1", 8'd255, 8'd1, 1, 255);
        run_pair("p1_255", 8'd1, 8'd255, 1, 255);
        run_pair("p48_36", 8'd48, 8'd36, 12, 4);

        // Backpressure: hold DONE for 10 cycles with stray in_valid pulses.
        start_and_wait(8'd21, 8'd14, cyc);
        check_eq("bp_latency", 32'(cyc), 32'd3);
        held = out_gcd;
        check_eq("bp_gcd", 32'(held), 32'd7);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            in_a     = 8'd100;
            in_b     = 8'd10;
            @(negedge clk);
            check_eq("bp_hold_valid", 32'(out_valid), 32'd1);
            check_eq("bp_hold_gcd", 32'(out_gcd), 32'(held));
            check_eq("bp_busy", 32'(busy), 32'd1);
            check_eq("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("bp_release_valid", 32'(out_valid), 32'd0);
        check_eq("bp_release_in_ready", 32'(in_ready), 32'd1);
        run_pair("bp_next", 8'd100, 8'd10, 10, 10);

        // Reset during CALC discards the pending computation.
        in_a     = 8'd200;
        in_b     = 8'd3;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        check_eq("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_out_gcd", 32'(out_gcd), 32'd0);
        run_pair("after_rst", 8'd9, 8'd6, 3, 3);

        // Streaming with in_valid held high and random out_ready.
        for (int i = 0; i < 20; i++) begin
            pa[i] = 8'($urandom_range(0, 255));
            pb[i] = 8'($urandom_range(0, 255));
        end
        idx    = 0;
        ridx   = 0;
        budget = 0;
        while (ridx < 20 && budget < 60000) begin
            in_valid  = (idx < 20);
            in_a      = (idx < 20) ? pa[idx] : '0;
            in_b      = (idx < 20) ? pb[idx] : '0;
            out_ready = 1'($urandom_range(0, 1));
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready) begin
                check_eq($sformatf("stream_%0d_gcd_%0d_%0d", ridx, pa[ridx], pb[ridx]),
                         32'(out_gcd), 32'(ref_gcd(int'(pa[ridx]), int'(pb[ridx]))));
                ridx++;
            end
            @(negedge clk);
            budget++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_eq("stream_results", 32'(ridx), 32'd20);
        check_eq("stream_accepts", 32'(idx), 32'd20);
        @(negedge clk);
        check_eq("stream_idle", 32'(in_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
